// File: rtl/imm_gen_pipe.sv
// Registered immediate generator with a 2-entry skid buffer (OUT + SKID) and tag passthrough.
// Define IMM_GEN_CSR_ZIMM_EN to make format 110 a legal CSR zimm; otherwise 110 is flagged illegal.
module imm_gen_pipe #(
  parameter int XLEN  = 32,
  parameter int TAG_W = 5
) (
  input  logic             clk_i,
  input  logic             rst_n_i,
  input  logic             flush_i,
  input  logic             valid_i,
  output logic             ready_o,
  input  logic [31:0]      instr_i,
  input  logic [2:0]       imm_src_i,
  input  logic             signed_i,
  input  logic [TAG_W-1:0] tag_i,
  output logic             valid_o,
  input  logic             ready_i,
  output logic [XLEN-1:0]  imm_ext_o,
  output logic [TAG_W-1:0] tag_o,
  output logic             illegal_o
);

  localparam bit WIDE = (XLEN == 64);

  logic [63:0]      imm_full;
  logic [XLEN-1:0]  imm_next;
  logic             illegal_next;
  logic [5:0]       shamt_sext_field;
  logic [5:0]       shamt_zext_field;
  logic             unused_sink;

  logic             out_valid;
  logic [XLEN-1:0]  out_imm;
  logic [TAG_W-1:0] out_tag;
  logic             out_illegal;

  logic             skid_valid;
  logic [XLEN-1:0]  skid_imm;
  logic [TAG_W-1:0] skid_tag;
  logic             skid_illegal;

  logic             accept;
  logic             consume;

  // Formats are decoded at 64 bits and truncated, so RV32 and RV64 share one decoder.
  always_comb begin
    imm_full         = 64'd0;
    illegal_next     = 1'b0;
    shamt_sext_field = WIDE ? instr_i[25:20] : {instr_i[24], instr_i[24:20]};
    shamt_zext_field = WIDE ? instr_i[25:20] : {1'b0, instr_i[24:20]};
    case (imm_src_i)
      3'b000: begin
        if (signed_i) imm_full = {{52{instr_i[31]}}, instr_i[31:20]};
        else          imm_full = {52'd0, instr_i[31:20]};
      end
      3'b001: imm_full = {{52{instr_i[31]}}, instr_i[31:25], instr_i[11:7]};
      3'b010: imm_full = {{51{instr_i[31]}}, instr_i[31], instr_i[7],
                          instr_i[30:25], instr_i[11:8], 1'b0};
      3'b011: imm_full = {{32{instr_i[31]}}, instr_i[31:12], 12'd0};
      3'b100: imm_full = {{43{instr_i[31]}}, instr_i[31], instr_i[19:12],
                          instr_i[20], instr_i[30:21], 1'b0};
      3'b101: begin
        if (signed_i) imm_full = {{58{shamt_sext_field[5]}}, shamt_sext_field};
        else          imm_full = {58'd0, shamt_zext_field};
      end
      3'b111: imm_full = {51'd0, instr_i[31], instr_i[7],
                          instr_i[30:25], instr_i[11:8], 1'b0};
      3'b110: begin
`ifdef IMM_GEN_CSR_ZIMM_EN
        imm_full     = {59'd0, instr_i[19:15]};
        illegal_next = 1'b0;
`else
        imm_full     = 64'd0;
        illegal_next = 1'b1;
`endif
      end
      default: begin
        imm_full     = 64'd0;
        illegal_next = 1'b1;
      end
    endcase
  end

  assign imm_next    = imm_full[XLEN-1:0];
  assign unused_sink = ^{instr_i[6:0], imm_full};

  assign ready_o = !skid_valid;
  assign accept  = valid_i && ready_o && !flush_i;
  assign consume = out_valid && ready_i;

  // OUT refills from SKID first so results stay in acceptance order.
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      out_valid    <= 1'b0;
      out_imm      <= '0;
      out_tag      <= '0;
      out_illegal  <= 1'b0;
      skid_valid   <= 1'b0;
      skid_imm     <= '0;
      skid_tag     <= '0;
      skid_illegal <= 1'b0;
    end else if (flush_i) begin
      out_valid  <= 1'b0;
      skid_valid <= 1'b0;
    end else if (!out_valid || consume) begin
      if (skid_valid) begin
        out_valid   <= 1'b1;
        out_imm     <= skid_imm;
        out_tag     <= skid_tag;
        out_illegal <= skid_illegal;
        skid_valid  <= 1'b0;
      end else if (accept) begin
        out_valid   <= 1'b1;
        out_imm     <= imm_next;
        out_tag     <= tag_i;
        out_illegal <= illegal_next;
      end else begin
        out_valid <= 1'b0;
      end
    end else if (accept) begin
      skid_valid   <= 1'b1;
      skid_imm     <= imm_next;
      skid_tag     <= tag_i;
      skid_illegal <= illegal_next;
    end
  end

  assign valid_o   = out_valid;
  assign imm_ext_o = out_imm;
  assign tag_o     = out_tag;
  assign illegal_o = out_illegal;

endmodule

// File: tb/tb_imm_gen_pipe.sv
// Self-checking bench for imm_gen_pipe: RV32 and RV64 instances share stimulus and are
// checked against a queue-based reference model; honours IMM_GEN_CSR_ZIMM_EN if defined.
module tb_imm_gen_pipe;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        flush;
  logic        valid_in;
  logic [31:0] instr;
  logic [2:0]  imm_src;
  logic        sgn;
  logic [4:0]  tag_in;
  logic        ready_in;

  logic        ready32, valid32, ill32;
  logic [31:0] imm32;
  logic [4:0]  tag32;
  logic        ready64, valid64, ill64;
  logic [63:0] imm64;
  logic [4:0]  tag64;

  int vectors = 0;
  int miscompares = 0;

  typedef struct {
    logic [63:0] imm64;
    logic [31:0] imm32;
    logic [4:0]  tag;
    logic        ill;
  } res_t;
  res_t q[$];

  always #5 clk = ~clk;

  imm_gen_pipe #(.XLEN(32), .TAG_W(5)) dut32 (
    .clk_i(clk), .rst_n_i(rst_n), .flush_i(flush), .valid_i(valid_in), .ready_o(ready32),
    .instr_i(instr), .imm_src_i(imm_src), .signed_i(sgn), .tag_i(tag_in),
    .valid_o(valid32), .ready_i(ready_in), .imm_ext_o(imm32), .tag_o(tag32), .illegal_o(ill32)
  );

  imm_gen_pipe #(.XLEN(64), .TAG_W(5)) dut64 (
    .clk_i(clk), .rst_n_i(rst_n), .flush_i(flush), .valid_i(valid_in), .ready_o(ready64),
    .instr_i(instr), .imm_src_i(imm_src), .signed_i(sgn), .tag_i(tag_in),
    .valid_o(valid64), .ready_i(ready_in), .imm_ext_o(imm64), .tag_o(tag64), .illegal_o(ill64)
  );

  task automatic checkOutput(input string name, input logic [63:0] actual, input logic [63:0] expected);
    vectors++;
    if (actual !== expected) begin
      miscompares++;
      $display("[TB] FAIL %s: got %h, expected %h", name, actual, expected);
    end
  endtask

  function automatic longint sx(input longint v, input int bits);
    return (v >= (longint'(1) <<< (bits - 1))) ? v - (longint'(1) <<< bits) : v;
  endfunction

  // Reference decode using field arithmetic; result truncated to xlen.
  function automatic void refImm(input logic [31:0] ins, input logic [2:0] src, input logic s,
                                 input int xlen, output logic [63:0] val, output logic ill);
    longint f;
    longint bfield;
    int     n;
    ill = 1'b0;
    bfield = longint'(ins[31]) * 4096 + longint'(ins[7]) * 2048
           + longint'(ins[30:25]) * 32 + longint'(ins[11:8]) * 2;
    case (src)
      3'd0: f = s ? sx(longint'(ins[31:20]), 12) : longint'(ins[31:20]);
      3'd1: f = sx(longint'(ins[31:25]) * 32 + longint'(ins[11:7]), 12);
      3'd2: f = sx(bfield, 13);
      3'd3: f = sx(longint'(ins[31:12]) * 4096, 32);
      3'd4: f = sx(longint'(ins[31]) * 1048576 + longint'(ins[19:12]) * 4096
                 + longint'(ins[20]) * 2048 + longint'(ins[30:21]) * 2, 21);
      3'd5: begin
        n = (xlen == 64) ? 6 : 5;
        f = (longint'(ins) >> 20) & ((longint'(1) <<< n) - 1);
        if (s) f = sx(f, n);
      end
      3'd7: f = bfield;
      default: begin
`ifdef IMM_GEN_CSR_ZIMM_EN
        f = longint'(ins[19:15]);
`else
        f = 0;
        ill = 1'b1;
`endif
      end
    endcase
    val = (xlen == 32) ? {32'd0, f[31:0]} : f;
  endfunction

  task automatic checkModel();
    checkOutput("valid32", 64'(valid32), 64'(q.size() > 0));
    checkOutput("ready32", 64'(ready32), 64'(q.size() < 2));
    checkOutput("valid64", 64'(valid64), 64'(q.size() > 0));
    checkOutput("ready64", 64'(ready64), 64'(q.size() < 2));
    if (q.size() > 0) begin
      checkOutput("imm32", 64'(imm32), {32'd0, q[0].imm32});
      checkOutput("tag32", 64'(tag32), 64'(q[0].tag));
      checkOutput("ill32", 64'(ill32), 64'(q[0].ill));
      checkOutput("imm64", imm64, q[0].imm64);
      checkOutput("tag64", 64'(tag64), 64'(q[0].tag));
      checkOutput("ill64", 64'(ill64), 64'(q[0].ill));
    end
  endtask

  // One clock of stimulus; model decides accept/consume from its own occupancy.
  task automatic applyStimulus(input logic v, input logic [31:0] ins, input logic [2:0] src,
                               input logic s, input logic [4:0] t, input logic rdy,
                               input logic fl, output logic accepted);
    res_t        e;
    logic [63:0] v32;
    logic        il;
    logic        cons;
    valid_in = v; instr = ins; imm_src = src; sgn = s; tag_in = t; ready_in = rdy; flush = fl;
    accepted = v && (q.size() < 2) && !fl;
    cons     = (q.size() > 0) && rdy;
    refImm(ins, src, s, 32, v32, il);
    refImm(ins, src, s, 64, e.imm64, e.ill);
    e.imm32 = v32[31:0];
    e.tag   = t;
    if (fl) q.delete();
    else begin
      if (cons) void'(q.pop_front());
      if (accepted) q.push_back(e);
    end
    @(posedge clk);
    #1;
    checkModel();
  endtask

  initial begin
    logic acc;
    int   tg;
    int   cyc;
    rst_n = 1'b0; flush = 1'b0; valid_in = 1'b0; instr = '0; imm_src = '0;
    sgn = 1'b0; tag_in = '0; ready_in = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    checkOutput("rst_valid", 64'(valid32), 64'd0);
    checkOutput("rst_ready", 64'(ready32), 64'd1);
    checkOutput("rst_imm", 64'(imm32), 64'd0);
    checkOutput("rst_tag", 64'(tag32), 64'd0);
    checkOutput("rst_ill", 64'(ill32), 64'd0);
    checkOutput("rst_imm64", imm64, 64'd0);
    rst_n = 1'b1;

    applyStimulus(1, 32'hFFF00093, 3'b000, 1, 5'd1, 1, 0, acc);
    checkOutput("i_sext", 64'(imm32), 64'h0000_0000_FFFF_FFFF);
    applyStimulus(1, 32'hFFF00093, 3'b000, 0, 5'd2, 1, 0, acc);
    checkOutput("i_zext", 64'(imm32), 64'h0000_0000_0000_0FFF);
    applyStimulus(1, 32'hFE000EE3, 3'b010, 0, 5'd3, 1, 0, acc);
    checkOutput("b_sext", 64'(imm32), 64'h0000_0000_FFFF_FFFC);
    applyStimulus(1, 32'hFE000EE3, 3'b111, 0, 5'd4, 1, 0, acc);
    checkOutput("b_zext", 64'(imm32), 64'h0000_0000_0000_1FFC);
    applyStimulus(1, 32'h800002B7, 3'b011, 0, 5'd5, 1, 0, acc);
    checkOutput("u_rv64", imm64, 64'hFFFF_FFFF_8000_0000);
    applyStimulus(1, 32'h03F01013, 3'b101, 0, 5'd6, 1, 0, acc);
    checkOutput("shamt64", imm64, 64'h0000_0000_0000_003F);
    checkOutput("shamt32", 64'(imm32), 64'h0000_0000_0000_001F);
    applyStimulus(1, 32'h3400D073, 3'b110, 0, 5'd7, 1, 0, acc);
`ifdef IMM_GEN_CSR_ZIMM_EN
    checkOutput("zimm_val", 64'(imm32), 64'd1);
    checkOutput("zimm_ill", 64'(ill32), 64'd0);
`else
    checkOutput("zimm_val", 64'(imm32), 64'd0);
    checkOutput("zimm_ill", 64'(ill32), 64'd1);
`endif
    applyStimulus(0, 32'd0, 3'b000, 0, 5'd0, 1, 0, acc);

    // Backpressure: tags 1..4 with ready low for three cycles.
    tg = 1;
    cyc = 0;
    while (tg <= 4 && cyc < 20) begin
      applyStimulus(1, 32'h00100093, 3'b000, 1, 5'(tg), cyc >= 3, 0, acc);
      if (acc) tg++;
      cyc++;
      if (cyc == 2) checkOutput("bp_ready_low", 64'(ready32), 64'd0);
    end
    checkOutput("bp_all_accepted", 64'(tg), 64'd5);
    repeat (4) applyStimulus(0, 32'd0, 3'b000, 0, 5'd0, 1, 0, acc);
    checkOutput("bp_ready_back", 64'(ready32), 64'd1);
    checkOutput("bp_drained", 64'(valid32), 64'd0);

    // Flush with OUT and SKID full plus a live input.
    applyStimulus(1, 32'h12345093, 3'b000, 1, 5'd10, 0, 0, acc);
    applyStimulus(1, 32'h54321093, 3'b000, 1, 5'd11, 0, 0, acc);
    applyStimulus(1, 32'h0AA00093, 3'b000, 1, 5'd9, 0, 1, acc);
    checkOutput("flush_valid", 64'(valid32), 64'd0);
    checkOutput("flush_ready", 64'(ready32), 64'd1);
    repeat (2) applyStimulus(0, 32'd0, 3'b000, 0, 5'd0, 1, 0, acc);
    checkOutput("flush_dropped", 64'(valid32), 64'd0);

    repeat (300) begin
      applyStimulus($urandom_range(0, 3) != 0, 32'($urandom), 3'($urandom_range(0, 7)),
                    1'($urandom_range(0, 1)), 5'($urandom_range(0, 31)),
                    $urandom_range(0, 2) != 0, $urandom_range(0, 19) == 0, acc);
    end

    // Asynchronous reset mid-stream, away from a clock edge.
    applyStimulus(1, 32'hFFF00093, 3'b000, 1, 5'd12, 0, 0, acc);
    applyStimulus(1, 32'hFFF00093, 3'b000, 1, 5'd13, 0, 0, acc);
    #3;
    rst_n = 1'b0;
    #1;
    checkOutput("async_valid32", 64'(valid32), 64'd0);
    checkOutput("async_ready32", 64'(ready32), 64'd1);
    checkOutput("async_valid64", 64'(valid64), 64'd0);
    checkOutput("async_ready64", 64'(ready64), 64'd1);
    q.delete();
    #2;
    rst_n = 1'b1;
    repeat (3) applyStimulus(1, 32'h00500093, 3'b000, 1, 5'd14, 1, 0, acc);
    applyStimulus(0, 32'd0, 3'b000, 0, 5'd0, 1, 0, acc);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
